// File: rtl/soc_pio_arb_pkg.sv
// Shared types and constants for the two-port PIO read arbiter.
package soc_pio_arb_pkg;

  // Transaction phases of one serialised slave read.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

  // Largest legal slave latency; the package-level counter width covers it.
  localparam int MAX_READ_LATENCY = 7;
  localparam int LAT_CNT_W        = $clog2(MAX_READ_LATENCY + 1);

  // Requester ids as stored in the id latch.
  localparam logic REQ_HPS    = 1'b0;
  localparam logic REQ_FABRIC = 1'b1;

  // Counter width for a specific latency build.
  function automatic int lat_cnt_w(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/soc_pio_rr_arbiter.sv
// Two-way grant logic: one-hot grant from the current requests, with a
// last-granted pointer that only moves when a grant is actually accepted.
module soc_pio_rr_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_grant
);
  import soc_pio_arb_pkg::*;

  // Id granted most recently; resets to the fabric side so m0 wins the first tie.
  logic       r_last;
  logic [1:0] w_grant;

  // Grant: a lone requester always wins; on a tie the port not served last
  // wins, unless fixed priority pins the tie to m0.
  always_comb begin
    w_grant = 2'b00;
    case (i_req)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = ((FIXED_PRIO != 0) || (r_last == REQ_FABRIC)) ? 2'b01 : 2'b10;
      default: w_grant = 2'b00;
    endcase
  end

  assign o_grant = w_grant;

  // Pointer update on accept only, so a withdrawn request never moves it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_last <= REQ_FABRIC;
    else if (i_accept) r_last <= w_grant[1];
  end

endmodule

// File: rtl/soc_system_pio_rd_arbiter.sv
// Serialises reads from the HPS bridge (m0) and the chess-clock controller
// (m1) onto one read-only PIO slave with fixed readdata latency.
module soc_system_pio_rd_arbiter
  import soc_pio_arb_pkg::*;
#(
  parameter int ADDR_W       = 3,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int FIXED_PRIO   = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_read,
  input  logic [ADDR_W-1:0] m0_address,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic              m1_read,
  input  logic [ADDR_W-1:0] m1_address,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] s_address,
  input  logic [DATA_W-1:0] s_readdata
);

  localparam int CNT_W = lat_cnt_w(READ_LATENCY);

  arb_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_saddr;
  logic              r_id;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic [1:0]        r_valid;

  logic [1:0]        w_req;
  logic [1:0]        w_grant;
  logic              w_idle;
  logic              w_accept;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_last_wait;

  assign w_req       = {m1_read, m0_read};
  assign w_idle      = (r_state == ST_IDLE);
  assign w_accept    = w_idle && (|(w_grant & w_req));
  assign w_sel_addr  = w_grant[1] ? m1_address : m0_address;
  assign w_last_wait = (r_state == ST_WAIT) && (r_cnt == CNT_W'(1));

  soc_pio_rr_arbiter #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_req    (w_req),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  // Waitrequest drops only for the granted, requesting port while idle and
  // out of reset; requests arriving mid-transaction simply wait.
  assign m0_waitrequest = ~(reset_n & w_idle & w_grant[0] & m0_read);
  assign m1_waitrequest = ~(reset_n & w_idle & w_grant[1] & m1_read);

  assign s_address        = r_saddr;
  assign m0_readdata      = r_rdata0;
  assign m1_readdata      = r_rdata1;
  assign m0_readdatavalid = r_valid[0];
  assign m1_readdatavalid = r_valid[1];

  // Phase sequencing plus address/id latch; s_address only changes on accept
  // so the slave sees no spurious traffic between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_saddr <= '0;
      r_id    <= REQ_HPS;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_saddr <= w_sel_addr;
          r_id    <= w_grant[1];
          r_state <= ST_ADDR;
        end
        ST_ADDR: r_state <= ST_WAIT;
        ST_WAIT: if (w_last_wait) r_state <= ST_RESP;
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Latency counter: loaded once the address has been stable for a cycle,
  // then counted down through the wait phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  r_cnt <= '0;
    else if (r_state == ST_ADDR)   r_cnt <= CNT_W'(READ_LATENCY);
    else if (r_state == ST_WAIT)   r_cnt <= r_cnt - CNT_W'(1);
  end

  // Return path: capture slave data for the granted port only and raise its
  // valid for the single response cycle; the other port's data is untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_valid  <= 2'b00;
    end else begin
      r_valid <= 2'b00;
      if (w_last_wait) begin
        if (r_id == REQ_FABRIC) r_rdata1 <= s_readdata;
        else                    r_rdata0 <= s_readdata;
        r_valid[r_id] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_soc_system_pio_rd_arbiter.sv
// Bench for the PIO read arbiter: a transaction-level model checks DUT A
// every cycle, with directed literal checks; DUT B is a latency-3,
// fixed-priority build checked with literal expectations.
module tb_soc_system_pio_rd_arbiter;

  localparam int A_RL = 1;
  localparam int A_FP = 0;
  localparam int B_RL = 3;
  localparam int B_FP = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  a_read, b_read;
  logic [2:0]  a_addr [2];
  logic [2:0]  b_addr [2];
  logic [1:0]  a_wr, b_wr, a_val, b_val;
  logic [31:0] a_rd [2];
  logic [31:0] b_rd [2];
  logic [2:0]  a_saddr, b_saddr;
  logic [31:0] a_srd, b_srd;
  logic [31:0] mem [8];

  int errors = 0;
  int checks = 0;
  int gq[$];

  always #5 clk = ~clk;

  soc_system_pio_rd_arbiter #(.ADDR_W(3), .DATA_W(32), .READ_LATENCY(A_RL), .FIXED_PRIO(A_FP)) u_dut_a (
    .clk(clk), .reset_n(rst_n),
    .m0_read(a_read[0]), .m0_address(a_addr[0]), .m0_waitrequest(a_wr[0]),
    .m0_readdata(a_rd[0]), .m0_readdatavalid(a_val[0]),
    .m1_read(a_read[1]), .m1_address(a_addr[1]), .m1_waitrequest(a_wr[1]),
    .m1_readdata(a_rd[1]), .m1_readdatavalid(a_val[1]),
    .s_address(a_saddr), .s_readdata(a_srd));

  soc_system_pio_rd_arbiter #(.ADDR_W(3), .DATA_W(32), .READ_LATENCY(B_RL), .FIXED_PRIO(B_FP)) u_dut_b (
    .clk(clk), .reset_n(rst_n),
    .m0_read(b_read[0]), .m0_address(b_addr[0]), .m0_waitrequest(b_wr[0]),
    .m0_readdata(b_rd[0]), .m0_readdatavalid(b_val[0]),
    .m1_read(b_read[1]), .m1_address(b_addr[1]), .m1_waitrequest(b_wr[1]),
    .m1_readdata(b_rd[1]), .m1_readdatavalid(b_val[1]),
    .s_address(b_saddr), .s_readdata(b_srd));

  // Slave: registered readdata, one cycle after the address.
  always @(posedge clk) begin
    a_srd <= mem[a_saddr];
    b_srd <= mem[b_saddr];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic wr_of(input bit d, input int x);
    return d ? b_wr[x] : a_wr[x];
  endfunction
  function automatic logic val_of(input bit d, input int x);
    return d ? b_val[x] : a_val[x];
  endfunction
  function automatic logic [31:0] rd_of(input bit d, input int x);
    return d ? b_rd[x] : a_rd[x];
  endfunction
  task automatic drive(input bit d, input int x, input logic r, input logic [2:0] ad);
    if (d) begin b_read[x] = r; b_addr[x] = ad; end
    else   begin a_read[x] = r; a_addr[x] = ad; end
  endtask

  // ---------------- transaction-level model of DUT A ----------------
  int          m_cyc, m_free, m_pcyc, m_pport, m_g;
  bit          m_last, m_pend;
  logic [31:0] m_pdata;
  logic [31:0] m_hold [2];
  logic [2:0]  m_saddr;
  logic [1:0]  e_wr, e_val;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_cyc = 0; m_free = 0; m_last = 1'b1; m_pend = 1'b0;
      m_hold[0] = '0; m_hold[1] = '0; m_saddr = '0;
      chk("rst_wr", 64'(a_wr), 64'(2'b11));
      chk("rst_val", 64'(a_val), 64'(2'b00));
      chk("rst_rd0", 64'(a_rd[0]), 64'(0));
      chk("rst_rd1", 64'(a_rd[1]), 64'(0));
      chk("rst_saddr", 64'(a_saddr), 64'(0));
    end else begin
      // Who is served this cycle, if the slave path is free.
      m_g = -1;
      if (m_cyc >= m_free) begin
        if (a_read == 2'b11)  m_g = (A_FP != 0) ? 0 : (m_last ? 0 : 1);
        else if (a_read[0])   m_g = 0;
        else if (a_read[1])   m_g = 1;
      end
      e_wr = 2'b11;
      if (m_g >= 0) e_wr[m_g] = 1'b0;
      e_val = 2'b00;
      if (m_pend && m_cyc == m_pcyc) begin
        e_val[m_pport]  = 1'b1;
        m_hold[m_pport] = m_pdata;
        m_pend          = 1'b0;
      end
      chk("wr", 64'(a_wr), 64'(e_wr));
      chk("val", 64'(a_val), 64'(e_val));
      chk("rd0", 64'(a_rd[0]), 64'(m_hold[0]));
      chk("rd1", 64'(a_rd[1]), 64'(m_hold[1]));
      chk("saddr", 64'(a_saddr), 64'(m_saddr));
      if (m_g >= 0) begin
        m_last  = (m_g == 1);
        m_saddr = a_addr[m_g];
        m_pend  = 1'b1;
        m_pport = m_g;
        m_pcyc  = m_cyc + A_RL + 2;
        m_pdata = mem[a_addr[m_g]];
        m_free  = m_cyc + A_RL + 3;
      end
      m_cyc++;
    end
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  // Single read from idle: accepted at once, valid after exp_lat cycles.
  task automatic read_wait(input bit d, input int x, input logic [2:0] ad,
                           input int exp_lat, input logic [31:0] exp_data, input string nm);
    int tries, lat;
    bit acc;
    acc = 0; tries = 0; lat = 0;
    drive(d, x, 1'b1, ad);
    while (!acc && tries < 40) begin
      @(negedge clk);
      tries++;
      if (!wr_of(d, x)) acc = 1;
      else step();
    end
    chk({nm, "_acc_first"}, 64'(tries), 64'(1));
    step();
    drive(d, x, 1'b0, ad);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (val_of(d, x)) begin lat = k; break; end
    end
    chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({nm, "_data"}, 64'(rd_of(d, x)), 64'(exp_data));
    chk({nm, "_other_val"}, 64'(val_of(d, 1 - x)), 64'(0));
    step();
  endtask

  // Both ports request together each round; records grant order in gq.
  task automatic both_rounds(input bit d, input int rounds, input string nm);
    int guard;
    logic [1:0] pend;
    gq.delete();
    for (int r = 0; r < rounds; r++) begin
      drive(d, 0, 1'b1, 3'(r));
      drive(d, 1, 1'b1, 3'(r + 4));
      pend = 2'b11; guard = 0;
      while (pend != 2'b00 && guard < 40) begin
        @(negedge clk);
        for (int x = 0; x < 2; x++)
          if (pend[x] && !wr_of(d, x)) begin gq.push_back(x); pend[x] = 1'b0; end
        step();
        for (int x = 0; x < 2; x++)
          if (!pend[x]) drive(d, x, 1'b0, 3'd0);
        guard++;
      end
      chk({nm, "_timeout"}, 64'(pend), 64'(0));
      repeat (8) step();
    end
    chk({nm, "_count"}, 64'(gq.size()), 64'(2 * rounds));
    for (int i = 0; i < gq.size(); i++)
      chk($sformatf("%s_ord%0d", nm, i), 64'(gq[i]), 64'(i % 2));
  endtask

  task automatic random_phase(input int n);
    bit acc [2];
    acc[0] = 0; acc[1] = 0;
    for (int i = 0; i < n; i++) begin
      for (int x = 0; x < 2; x++) begin
        if (a_read[x] && acc[x]) begin
          a_read[x] = ($urandom_range(2) == 0);
          a_addr[x] = 3'($urandom_range(7));
        end else if (a_read[x]) begin
          if ($urandom_range(40) == 0) a_read[x] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          a_read[x] = 1'b1;
          a_addr[x] = 3'($urandom_range(7));
        end
      end
      @(negedge clk);
      for (int x = 0; x < 2; x++) acc[x] = a_read[x] && !a_wr[x];
      step();
    end
    a_read = 2'b00;
    repeat (8) step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c0, c1, guard;
    rst_n  = 1'b0;
    a_read = 2'b00; b_read = 2'b00;
    a_addr[0] = '0; a_addr[1] = '0; b_addr[0] = '0; b_addr[1] = '0;
    mem[0] = 32'hDEAD_BEEF;
    mem[3] = 32'h0;
    for (int i = 1; i < 8; i++) if (i != 3) mem[i] = $urandom;
    repeat (3) step();
    rst_n = 1'b1;

    // Single m0 read from reset.
    read_wait(0, 0, 3'd0, 3, 32'hDEAD_BEEF, "t1");

    // Tie-breaking from a fresh reset: m0 first, then alternate.
    pulse_reset();
    both_rounds(0, 4, "t2");

    // m1 reads undecoded address 3; m0 arrives during m1's wait phase.
    drive(0, 1, 1'b1, 3'd3);
    @(negedge clk); chk("t3_m1_acc", 64'(a_wr[1]), 64'(0));
    step(); drive(0, 1, 1'b0, 3'd3);
    step(); drive(0, 0, 1'b1, 3'd2);
    @(negedge clk); chk("t3_m0_wr_wait", 64'(a_wr[0]), 64'(1));
    step();
    @(negedge clk);
    chk("t3_m1_val", 64'(a_val), 64'(2'b10));
    chk("t3_m1_data", 64'(a_rd[1]), 64'(0));
    chk("t3_m0_wr_resp", 64'(a_wr[0]), 64'(1));
    chk("t3_saddr", 64'(a_saddr), 64'(3));
    step();
    @(negedge clk); chk("t3_m0_acc", 64'(a_wr[0]), 64'(0));
    step(); drive(0, 0, 1'b0, 3'd2);
    repeat (3) @(negedge clk);
    chk("t3_m0_val", 64'(a_val), 64'(2'b01));
    chk("t3_m0_data", 64'(a_rd[0]), 64'(mem[2]));
    step();

    // Reset during the wait phase drops the read.
    drive(0, 0, 1'b1, 3'd0);
    @(negedge clk); chk("t4_acc", 64'(a_wr[0]), 64'(0));
    step(); drive(0, 0, 1'b0, 3'd0);
    step(); rst_n = 1'b0;
    @(negedge clk);
    chk("t4_val", 64'(a_val), 64'(0));
    chk("t4_wr", 64'(a_wr), 64'(2'b11));
    step(); step(); rst_n = 1'b1;
    @(negedge clk); chk("t4_no_late_val", 64'(a_val), 64'(0));
    step();
    read_wait(0, 0, 3'd0, 3, 32'hDEAD_BEEF, "t4_after");

    // Randomised traffic against the model.
    random_phase(3000);

    // Latency-3, fixed-priority build.
    pulse_reset();
    read_wait(1, 0, 3'd0, 5, 32'hDEAD_BEEF, "b_lat");
    b_read = 2'b11; b_addr[0] = 3'd1; b_addr[1] = 3'd2;
    c0 = 0; c1 = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (!b_wr[0]) c0++;
      if (!b_wr[1]) c1++;
      step();
    end
    chk("b_fp_m0_grants", 64'(c0), 64'(4));
    chk("b_fp_m1_starved", 64'(c1), 64'(0));
    b_read[0] = 1'b0;
    guard = 0; c1 = 0;
    while (c1 == 0 && guard < 20) begin
      @(negedge clk);
      if (!b_wr[1]) c1 = 1;
      step();
      guard++;
    end
    chk("b_m1_after_release", 64'(c1), 64'(1));
    b_read = 2'b00;
    repeat (8) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
